// File: rtl/seq_pattern_tx_if.sv
// Bus between the serial pattern transmitter and its controller/observer.
// The slave modport is the transmitter's view of the bus.
interface seq_pattern_tx_if #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned REPEAT_W = 4
);
    logic                start;
    logic                abort;
    logic [WIDTH-1:0]    pattern;
    logic [REPEAT_W-1:0] repeat_cnt;
    logic                bit_out;
    logic                bit_valid;
    logic                busy;
    logic                done;
    logic [1:0]          state;

    modport master (
        output start,
        output abort,
        output pattern,
        output repeat_cnt,
        input  bit_out,
        input  bit_valid,
        input  busy,
        input  done,
        input  state
    );

    modport slave (
        input  start,
        input  abort,
        input  pattern,
        input  repeat_cnt,
        output bit_out,
        output bit_valid,
        output busy,
        output done,
        output state
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured word MSB-first, repeated, with optional
// even-parity bit per repetition when SEQ_TX_PARITY_EN is defined.
module seq_pattern_tx #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned REPEAT_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    seq_pattern_tx_if.slave tx
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SEQ_TX_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StShift  = 2'b01,
        StParity = 2'b10,
        StDone   = 2'b11
    } state_e;

    state_e              r_state;
    logic [WIDTH-1:0]    r_shift;
    logic [WIDTH-1:0]    r_word;
    logic [CntW-1:0]     r_bit_cnt;
    logic [REPEAT_W-1:0] r_rem;
    logic                r_bit_out;
    logic                r_bit_valid;
    logic                r_busy;
    logic                r_done;

    logic w_last_bit;
    logic w_word_end;
    logic w_more;

    assign w_last_bit = (r_bit_cnt == CntW'(WIDTH - 1));
    assign w_more     = (r_rem != '0);
    // A repetition ends on the parity bit if it exists, otherwise on the last data bit.
    assign w_word_end = ParityEn ? (r_state == StParity)
                                 : ((r_state == StShift) && w_last_bit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_word      <= '0;
            r_bit_cnt   <= '0;
            r_rem       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (tx.start && !tx.abort) begin
                        r_word      <= tx.pattern;
                        r_shift     <= tx.pattern << 1;
                        r_bit_cnt   <= '0;
                        r_rem       <= (tx.repeat_cnt == '0) ? '0
                                                             : tx.repeat_cnt - REPEAT_W'(1);
                        r_bit_out   <= tx.pattern[WIDTH-1];
                        r_bit_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= StShift;
                    end
                end
                StShift, StParity: begin
                    if (tx.abort) begin
                        r_state     <= StIdle;
                        r_bit_out   <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_word_end) begin
                        if (w_more) begin
                            r_rem     <= r_rem - REPEAT_W'(1);
                            r_shift   <= r_word << 1;
                            r_bit_cnt <= '0;
                            r_bit_out <= r_word[WIDTH-1];
                            r_state   <= StShift;
                        end else begin
                            r_state     <= StDone;
                            r_bit_out   <= 1'b0;
                            r_bit_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end else if (w_last_bit) begin
                        // Only reachable with parity compiled in.
                        r_state   <= StParity;
                        r_bit_out <= ^r_word;
                    end else begin
                        r_bit_out <= r_shift[WIDTH-1];
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt + CntW'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= StIdle;
                    r_bit_out   <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign tx.bit_out   = r_bit_out;
    assign tx.bit_valid = r_bit_valid;
    assign tx.busy      = r_busy;
    assign tx.done      = r_done;
    assign tx.state     = r_state;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized self-checking bench for seq_pattern_tx; expected streams come from a
// queue-based model of the frame (R repetitions of MSB-first word plus optional parity).
module tb_seq_pattern_tx;
    localparam int unsigned W  = 4;
    localparam int unsigned RW = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_pattern_tx_if #(.WIDTH(W), .REPEAT_W(RW)) u_if ();

    seq_pattern_tx #(.WIDTH(W), .REPEAT_W(RW)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .tx      (u_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_state"}, 32'(u_if.state), 0);
        check_eq({tag, "_valid"}, 32'(u_if.bit_valid), 0);
        check_eq({tag, "_bit"}, 32'(u_if.bit_out), 0);
        check_eq({tag, "_busy"}, 32'(u_if.busy), 0);
        check_eq({tag, "_done"}, 32'(u_if.done), 0);
    endtask

    // Call right after a negedge with start already driven for this frame.
    task automatic run_frame(input logic [W-1:0] pat, input int rep, input int abort_idx,
                             input bit hold, input logic [W-1:0] npat, input int nrep);
        bit exp_q[$];
        int r;
        int n;
        r = (rep == 0) ? 1 : rep;
        for (int k = 0; k < r; k++) begin
            for (int b = W - 1; b >= 0; b--) exp_q.push_back(pat[b]);
            if (P == 1) exp_q.push_back(^pat);
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("valid", 32'(u_if.bit_valid), 1);
            check_eq($sformatf("bit%0d", i), 32'(u_if.bit_out), 32'(exp_q[i]));
            check_eq("state_tx", 32'(u_if.state),
                     (P == 1 && (i % (W + P)) == W) ? 2 : 1);
            check_eq("busy_tx", 32'(u_if.busy), 1);
            check_eq("done_tx", 32'(u_if.done), 0);
            if (i == 0 && !hold) u_if.start = 1'b0;
            if (i == 1) begin
                u_if.pattern    = npat;
                u_if.repeat_cnt = RW'(nrep);
            end
            if (i == abort_idx) begin
                u_if.abort = 1'b1;
                @(negedge clk);
                u_if.abort = 1'b0;
                check_idle("abort");
                @(negedge clk);
                check_idle("post_abort");
                return;
            end
        end
        @(negedge clk);
        check_eq("done_pulse", 32'(u_if.done), 1);
        check_eq("done_valid", 32'(u_if.bit_valid), 0);
        check_eq("done_bit", 32'(u_if.bit_out), 0);
        check_eq("done_state", 32'(u_if.state), 3);
        check_eq("done_busy", 32'(u_if.busy), 1);
        @(negedge clk);
        check_idle("end");
    endtask

    task automatic drive_start(input logic [W-1:0] pat, input int rep);
        u_if.start      = 1'b1;
        u_if.abort      = 1'b0;
        u_if.pattern    = pat;
        u_if.repeat_cnt = RW'(rep);
    endtask

    initial begin
        logic [W-1:0] p1;
        logic [W-1:0] p2;
        int           r2;
        int           ab;

        u_if.start      = 1'b1;
        u_if.abort      = 1'b0;
        u_if.pattern    = '0;
        u_if.repeat_cnt = '0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;

        repeat (2) @(negedge clk);
        check_idle("reset");
        u_if.start = 1'b0;
        rst_n      = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("released");

        // Basic word, with inputs changed mid-frame.
        drive_start(4'b1001, 1);
        run_frame(4'b1001, 1, -1, 1'b0, 4'b0110, 5);

        drive_start(4'b1011, 2);
        run_frame(4'b1011, 2, -1, 1'b0, 4'b0000, 0);

        // repeat_cnt=0 sends once; start held gives back-to-back frames.
        p1 = 4'b0111;
        p2 = 4'b1010;
        drive_start(p1, 0);
        run_frame(p1, 0, -1, 1'b1, p2, 2);
        run_frame(p2, 2, -1, 1'b0, p2, 2);

        // Abort on the third bit, then a full new word.
        drive_start(4'b1100, 1);
        run_frame(4'b1100, 1, 2, 1'b0, 4'b1100, 1);
        drive_start(4'b0101, 1);
        run_frame(4'b0101, 1, -1, 1'b0, 4'b0101, 1);

        // Abort and start together in IDLE: nothing starts.
        u_if.start = 1'b1;
        u_if.abort = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.abort = 1'b0;
        check_idle("abort_start");

        // Asynchronous reset mid-frame.
        drive_start(4'b1111, 3);
        @(negedge clk);
        u_if.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_rst");
        drive_start(4'b1110, 1);
        run_frame(4'b1110, 1, -1, 1'b0, 4'b0001, 3);

        for (int t = 0; t < 25; t++) begin
            p1 = W'($urandom);
            p2 = W'($urandom);
            r2 = $urandom_range(0, 3);
            ab = -1;
            if ($urandom_range(0, 3) == 0)
                ab = $urandom_range(0, ((r2 == 0) ? 1 : r2) * (W + P) - 1);
            drive_start(p1, r2);
            run_frame(p1, r2, ab, 1'b0, p2, $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
